hrm_io_bridge: RTL and testbench

- Host-side counterpart of the hrmcpu FIFO interface.
- Writes bytes from a host byte stream (e.g. UART RX) into the CPU INBOX.
- Drains the CPU OUTBOX onto a host byte stream (e.g. UART TX).
- On request, sweeps the INBOX/OUTBOX dump port and sends a length-prefixed snapshot on the same TX stream. Sits between the UART/host logic and hrmcpu in the board top.

---
 rtl/hrm_io_pkg.sv | 18 +
 rtl/hrm_dump_seq.sv | 107 ++++++++++
 rtl/hrm_io_bridge.sv | 126 ++++++++++++
 tb/tb_hrm_io_bridge.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hrm_io_pkg.sv
// Shared definitions for the host-side hrmcpu FIFO bridge: FSM encodings,
// the default FIFO depth exponent and the width of the dump entry counter.
package hrm_io_pkg;

    localparam int DEFAULT_LGFLEN = 5;

    // The dump counter must reach 2**lgflen, so it needs one extra bit.
    function automatic int dump_cnt_w(input int lgflen);
        return lgflen + 1;
    endfunction

    localparam int DUMP_CNT_W = dump_cnt_w(DEFAULT_LGFLEN);

    typedef enum logic [1:0] {IN_IDLE, IN_WR, IN_GAP} in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_POP, O_SETTLE} o_state_t;
    typedef enum logic [1:0] {D_IDLE, D_COUNT, D_LEN, D_EMIT} d_state_t;

endpackage

// File: rtl/hrm_dump_seq.sv
// FIFO dump sequencer: counts the valid entries of the selected CPU FIFO
// through its dump port, then offers a length byte followed by the entries
// as a byte source to the bridge's tx register.
module hrm_dump_seq
    import hrm_io_pkg::*;
#(
    parameter int LGFLEN = DEFAULT_LGFLEN
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              dump_req,
    input  logic              dump_sel,
    input  logic              out_idle,
    input  logic [7:0]        dmp_data,
    input  logic              dmp_valid,
    input  logic              src_ready,
    output logic [7:0]        src_data,
    output logic              src_valid,
    output logic              dump_busy,
    output logic              dump_pending,
    output logic              fifo_sel,
    output logic [LGFLEN-1:0] dmp_pos
);
    localparam int CNT_W = dump_cnt_w(LGFLEN);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(2 ** LGFLEN);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [LGFLEN-1:0] POS_ONE  = LGFLEN'(1);

    d_state_t         state;
    logic [CNT_W-1:0] cnt;
    logic             settle;   // dump port result not yet valid for current pos
    logic             last_pos;

    // Source handshake: a byte moves when src_valid && src_ready in the same
    // cycle; src_data is only meaningful while src_valid is high.
    assign src_valid = (state == D_LEN) || ((state == D_EMIT) && !settle);
    assign src_data  = (state == D_LEN) ? 8'(cnt) : dmp_data;
    assign last_pos  = (CNT_W'(dmp_pos) == (cnt - CNT_ONE));

    // Dump FSM: request latch, entry count, length byte, entry emission.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            state        <= D_IDLE;
            cnt          <= '0;
            settle       <= 1'b0;
            dump_busy    <= 1'b0;
            dump_pending <= 1'b0;
            fifo_sel     <= 1'b0;
            dmp_pos      <= '0;
        end else begin
            case (state)
                D_IDLE: begin
                    if (dump_pending && out_idle) begin
                        dump_pending <= 1'b0;
                        dump_busy    <= 1'b1;
                        dmp_pos      <= '0;
                        cnt          <= '0;
                        settle       <= 1'b1;
                        state        <= D_COUNT;
                    end else if (dump_req) begin
                        dump_pending <= 1'b1;
                        fifo_sel     <= dump_sel;
                    end
                end
                D_COUNT: begin
                    if (settle) begin
                        settle <= 1'b0;
                    end else if (dmp_valid && (cnt != CNT_FULL)) begin
                        cnt     <= cnt + CNT_ONE;
                        dmp_pos <= dmp_pos + POS_ONE;
                        settle  <= 1'b1;
                    end else begin
                        state <= D_LEN;
                    end
                end
                D_LEN: begin
                    if (src_ready) begin
                        dmp_pos <= '0;
                        if (cnt == '0) begin
                            dump_busy <= 1'b0;
                            state     <= D_IDLE;
                        end else begin
                            settle <= 1'b1;
                            state  <= D_EMIT;
                        end
                    end
                end
                D_EMIT: begin
                    if (settle) begin
                        settle <= 1'b0;
                    end else if (src_ready) begin
                        if (last_pos) begin
                            dmp_pos   <= '0;
                            dump_busy <= 1'b0;
                            state     <= D_IDLE;
                        end else begin
                            dmp_pos <= dmp_pos + POS_ONE;
                            settle  <= 1'b1;
                        end
                    end
                end
                default: state <= D_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hrm_io_bridge.sv
// Host-side bridge to the hrmcpu FIFOs: host rx bytes go into the INBOX,
// OUTBOX bytes and on-demand FIFO snapshots go out on the host tx stream.
module hrm_io_bridge
    import hrm_io_pkg::*;
#(
    parameter int LGFLEN = DEFAULT_LGFLEN
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              dump_req,
    input  logic              dump_sel,
    output logic              dump_busy,
    output logic [7:0]        cpu_in_data,
    output logic              cpu_in_wr,
    input  logic              cpu_in_full,
    input  logic [7:0]        cpu_out_data,
    input  logic              cpu_out_empty,
    output logic              cpu_out_rd,
    output logic [LGFLEN-1:0] cpu_fifo_dmp_pos,
    output logic              cpu_fifo_sel,
    input  logic [7:0]        cpu_fifo_dmp_data,
    input  logic              cpu_fifo_dmp_valid
);
    in_state_t  in_state;
    o_state_t   o_state;
    logic [7:0] dmp_src_data;
    logic       dmp_src_valid;
    logic       dump_pending;

    // Host streams use valid/ready: a byte transfers on the cycle both are
    // high; the sender holds data stable while valid is high and ready low.
    assign rx_ready = i_rst && (in_state == IN_IDLE) && !cpu_in_full;

    // INBOX path: capture a host byte, pulse the write, then let full settle.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            in_state    <= IN_IDLE;
            cpu_in_wr   <= 1'b0;
            cpu_in_data <= 8'h00;
        end else begin
            case (in_state)
                IN_IDLE: begin
                    if (rx_valid && rx_ready) begin
                        cpu_in_data <= rx_data;
                        cpu_in_wr   <= 1'b1;
                        in_state    <= IN_WR;
                    end
                end
                IN_WR: begin
                    cpu_in_wr <= 1'b0;
                    in_state  <= IN_GAP;
                end
                IN_GAP:  in_state <= IN_IDLE;
                default: in_state <= IN_IDLE;
            endcase
        end
    end

    // OUTBOX path: pop one byte when the tx slot is free and no dump wants it.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            o_state    <= O_IDLE;
            cpu_out_rd <= 1'b0;
        end else begin
            case (o_state)
                O_IDLE: begin
                    if (!cpu_out_empty && !tx_valid && !dump_busy && !dump_pending) begin
                        cpu_out_rd <= 1'b1;
                        o_state    <= O_POP;
                    end
                end
                O_POP: begin
                    cpu_out_rd <= 1'b0;
                    o_state    <= O_SETTLE;
                end
                O_SETTLE: o_state <= O_IDLE;
                default:  o_state <= O_IDLE;
            endcase
        end
    end

    // tx register: loaded by an OUTBOX pop or by the dump source, never both.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
            if (o_state == O_POP) begin
                tx_data  <= cpu_out_data;
                tx_valid <= 1'b1;
            end else if (dmp_src_valid && !tx_valid) begin
                tx_data  <= dmp_src_data;
                tx_valid <= 1'b1;
            end
        end
    end

    hrm_dump_seq #(
        .LGFLEN (LGFLEN)
    ) u_dump_seq (
        .clk          (clk),
        .i_rst        (i_rst),
        .dump_req     (dump_req),
        .dump_sel     (dump_sel),
        .out_idle     (o_state == O_IDLE),
        .dmp_data     (cpu_fifo_dmp_data),
        .dmp_valid    (cpu_fifo_dmp_valid),
        .src_ready    (!tx_valid),
        .src_data     (dmp_src_data),
        .src_valid    (dmp_src_valid),
        .dump_busy    (dump_busy),
        .dump_pending (dump_pending),
        .fifo_sel     (cpu_fifo_sel),
        .dmp_pos      (cpu_fifo_dmp_pos)
    );

endmodule

// File: tb/tb_hrm_io_bridge.sv
// Bench for hrm_io_bridge: an hrmcpu FIFO model drives the CPU side, a
// negedge monitor checks every cycle against transaction-level expectations.
module tb_hrm_io_bridge;
    localparam int LGFLEN = 5;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              dump_req;
    logic              dump_sel;
    logic              dump_busy;
    logic [7:0]        cpu_in_data;
    logic              cpu_in_wr;
    logic              cpu_in_full;
    logic [7:0]        cpu_out_data;
    logic              cpu_out_empty;
    logic              cpu_out_rd;
    logic [LGFLEN-1:0] cpu_fifo_dmp_pos;
    logic              cpu_fifo_sel;
    logic [7:0]        cpu_fifo_dmp_data;
    logic              cpu_fifo_dmp_valid;

    hrm_io_bridge #(.LGFLEN(LGFLEN)) dut (
        .clk                (clk),
        .i_rst              (i_rst),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .dump_req           (dump_req),
        .dump_sel           (dump_sel),
        .dump_busy          (dump_busy),
        .cpu_in_data        (cpu_in_data),
        .cpu_in_wr          (cpu_in_wr),
        .cpu_in_full        (cpu_in_full),
        .cpu_out_data       (cpu_out_data),
        .cpu_out_empty      (cpu_out_empty),
        .cpu_out_rd         (cpu_out_rd),
        .cpu_fifo_dmp_pos   (cpu_fifo_dmp_pos),
        .cpu_fifo_sel       (cpu_fifo_sel),
        .cpu_fifo_dmp_data  (cpu_fifo_dmp_data),
        .cpu_fifo_dmp_valid (cpu_fifo_dmp_valid)
    );

    // CPU FIFO model and scoreboard state
    logic [7:0] ib_q[$];
    logic [7:0] ob_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] in_exp_q[$];
    logic [7:0] tx_log[$];
    int         wr_cyc_q[$];
    logic       force_full;
    logic       ev_push;
    logic [7:0] ev_push_data;
    logic       ev_pop;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_hs = -100;
    int n_rd = 0;
    int n_wr = 0;
    int n_rdy = 0;
    int busy_sel0 = 0;
    int busy_sel1 = 0;
    logic hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic rd_prev = 1'b0;
    logic rx_done, ob_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Combinational view of the CPU FIFOs as seen by the bridge
    task automatic update_cpu_inputs();
        int p;
        p = int'(cpu_fifo_dmp_pos);
        cpu_in_full   = force_full || (ib_q.size() >= DEPTH);
        cpu_out_empty = (ob_q.size() == 0);
        cpu_out_data  = (ob_q.size() != 0) ? ob_q[0] : 8'h00;
        if (!cpu_fifo_sel) begin
            cpu_fifo_dmp_valid = (p < ib_q.size());
            cpu_fifo_dmp_data  = (p < ib_q.size()) ? ib_q[p] : 8'h00;
        end else begin
            cpu_fifo_dmp_valid = (p < ob_q.size());
            cpu_fifo_dmp_data  = (p < ob_q.size()) ? ob_q[p] : 8'h00;
        end
    endtask

    // FIFO commits happen at the clock edge that ends the write/read cycle
    always @(posedge clk) begin
        #1;
        if (ev_push && ib_q.size() < DEPTH) ib_q.push_back(ev_push_data);
        if (ev_pop && ob_q.size() != 0) void'(ob_q.pop_front());
        ev_push = 1'b0;
        ev_pop  = 1'b0;
        update_cpu_inputs();
    end

    // Per-cycle compare against the expected streams and timing rules
    always @(negedge clk) begin
        cyc++;
        if (!i_rst) begin
            hold_prev = 1'b0;
            rd_prev   = 1'b0;
            last_hs   = -100;
        end else begin
            if (hold_prev) begin
                check("tx_hold_valid", tx_valid, 1);
                check("tx_hold_data", tx_data, hold_data);
            end
            if (tx_valid && tx_ready) begin
                tx_log.push_back(tx_data);
                if (exp_q.size() == 0) fail_now("tx_unexpected_byte");
                else check("tx_byte", tx_data, exp_q.pop_front());
            end
            hold_prev = tx_valid && !tx_ready;
            hold_data = tx_data;

            if (rx_ready) begin
                n_rdy++;
                check("rx_ready_while_full", cpu_in_full, 0);
                check("rx_ready_gap", (cyc - last_hs) >= 3, 1);
            end
            if (rx_valid && rx_ready) begin
                last_hs = cyc;
                in_exp_q.push_back(rx_data);
                wr_cyc_q.push_back(cyc + 1);
            end
            if (wr_cyc_q.size() != 0 && wr_cyc_q[0] == cyc) begin
                logic [7:0] e;
                void'(wr_cyc_q.pop_front());
                e = in_exp_q.pop_front();
                check("in_wr_timing", cpu_in_wr, 1);
                if (cpu_in_wr) check("in_wr_data", cpu_in_data, e);
            end else if (cpu_in_wr) begin
                fail_now("in_wr_spurious");
            end
            if (cpu_in_wr) begin
                n_wr++;
                ev_push      = 1'b1;
                ev_push_data = cpu_in_data;
            end

            if (cpu_out_rd) begin
                n_rd++;
                check("rd_not_empty", cpu_out_empty, 0);
                check("rd_not_during_dump", dump_busy, 0);
                check("rd_single_pulse", rd_prev, 0);
                if (!cpu_out_empty) begin
                    exp_q.push_back(cpu_out_data);
                    ev_pop = 1'b1;
                end
            end
            rd_prev = cpu_out_rd;
            if (dump_busy) begin
                if (cpu_fifo_sel) busy_sel1++;
                else busy_sel0++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_rx(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        if (k == 300) fail_now("rx_handshake_timeout");
        tick();
        rx_valid = 1'b0;
    endtask

    // Expected snapshot: length byte then the selected FIFO's entries
    task automatic start_dump(input logic sel);
        if (!sel) begin
            exp_q.push_back(8'(ib_q.size()));
            foreach (ib_q[i]) exp_q.push_back(ib_q[i]);
        end else begin
            exp_q.push_back(8'(ob_q.size()));
            foreach (ob_q[i]) exp_q.push_back(ob_q[i]);
        end
        dump_sel = sel;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            tick();
            if (exp_q.size() == 0 && !tx_valid && !dump_busy && ob_q.size() == 0 && !cpu_out_rd)
                break;
        end
        if (k == 3000) fail_now(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_cpu_in_wr"}, cpu_in_wr, 0);
        check({tag, "_cpu_in_data"}, cpu_in_data, 0);
        check({tag, "_cpu_out_rd"}, cpu_out_rd, 0);
        check({tag, "_dmp_pos"}, cpu_fifo_dmp_pos, 0);
        check({tag, "_fifo_sel"}, cpu_fifo_sel, 0);
        check({tag, "_dump_busy"}, dump_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x, a, b;
        logic [7:0] sent_q[$];
        int n0, k;
        i_rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        dump_req = 1'b0; dump_sel = 1'b0; force_full = 1'b0;
        ev_push = 1'b0; ev_push_data = 8'h00; ev_pop = 1'b0;
        update_cpu_inputs();
        repeat (3) tick();
        check_reset_outputs("reset");
        i_rst = 1'b1;
        tick();

        // three back-to-back host bytes into the INBOX
        send_rx(8'h11); send_rx(8'h22); send_rx(8'h33);
        repeat (3) tick();
        check("inbox_wr_count", n_wr, 3);
        check("inbox_0", ib_q[0], 8'h11);
        check("inbox_1", ib_q[1], 8'h22);
        check("inbox_2", ib_q[2], 8'h33);

        // INBOX full holds off the host for 10 cycles
        force_full = 1'b1; update_cpu_inputs();
        rx_data = 8'hA5; rx_valid = 1'b1;
        n_rdy = 0; n0 = n_wr;
        repeat (10) tick();
        check("full_no_ready", n_rdy, 0);
        check("full_no_write", n_wr, n0);
        force_full = 1'b0; update_cpu_inputs();
        send_rx(8'hA5);
        repeat (3) tick();
        check("full_release_write", n_wr, n0 + 1);
        check("full_release_data", ib_q[3], 8'hA5);

        // OUTBOX drain with host back-pressure
        n_rd = 0; tx_log.delete();
        ob_q.push_back(8'h05); ob_q.push_back(8'hF0); update_cpu_inputs();
        repeat (6) tick();
        check("ob_single_pop", n_rd, 1);
        check("ob_tx_valid", tx_valid, 1);
        check("ob_tx_data", tx_data, 8'h05);
        tx_ready = 1'b1;
        wait_idle("ob_drain_timeout");
        repeat (3) tick();
        check("ob_pop_count", n_rd, 2);
        check("ob_log_len", tx_log.size(), 2);
        check("ob_log_0", tx_log[0], 8'h05);
        check("ob_log_1", tx_log[1], 8'hF0);
        check("ob_idle_tx", tx_valid, 0);

        // INBOX dump of {7,8,9}
        ib_q.delete(); ib_q.push_back(8'h07); ib_q.push_back(8'h08); ib_q.push_back(8'h09);
        update_cpu_inputs();
        tx_log.delete(); busy_sel0 = 0; busy_sel1 = 0;
        start_dump(1'b0);
        wait_idle("dump3_timeout");
        check("dump3_len", tx_log.size(), 4);
        check("dump3_b0", tx_log[0], 8'h03);
        check("dump3_b1", tx_log[1], 8'h07);
        check("dump3_b2", tx_log[2], 8'h08);
        check("dump3_b3", tx_log[3], 8'h09);
        check("dump3_sel_inbox", (busy_sel0 > 0) && (busy_sel1 == 0), 1);
        check("dump3_pos_back", cpu_fifo_dmp_pos, 0);

        // empty and full dumps
        ib_q.delete(); update_cpu_inputs(); tx_log.delete();
        start_dump(1'b0);
        wait_idle("dump0_timeout");
        check("dump0_len", tx_log.size(), 1);
        check("dump0_b0", tx_log[0], 8'h00);
        for (int i = 0; i < DEPTH; i++) ib_q.push_back(8'($urandom));
        update_cpu_inputs(); tx_log.delete();
        start_dump(1'b0);
        wait_idle("dump32_timeout");
        check("dump32_len", tx_log.size(), 33);
        check("dump32_b0", tx_log[0], 8'h20);

        // OUTBOX byte held in tx goes before an OUTBOX dump, pops resume after
        tx_ready = 1'b0; tx_log.delete(); n_rd = 0;
        x = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
        ob_q.push_back(x); update_cpu_inputs();
        for (k = 0; k < 50; k++) begin
            tick();
            if (tx_valid) break;
        end
        check("held_x_loaded", tx_valid, 1);
        ob_q.push_back(a); ob_q.push_back(b); update_cpu_inputs();
        busy_sel0 = 0; busy_sel1 = 0;
        start_dump(1'b1);
        repeat (20) tick();
        check("obdump_no_pop", n_rd, 1);
        check("obdump_busy", dump_busy, 1);
        tx_ready = 1'b1;
        wait_idle("obdump_timeout");
        check("obdump_log_len", tx_log.size(), 6);
        check("obdump_b0", tx_log[0], x);
        check("obdump_b1", tx_log[1], 8'h02);
        check("obdump_b2", tx_log[2], a);
        check("obdump_b3", tx_log[3], b);
        check("obdump_b4", tx_log[4], a);
        check("obdump_b5", tx_log[5], b);
        check("obdump_sel_outbox", (busy_sel1 > 0) && (busy_sel0 == 0), 1);

        // random concurrent rx, OUTBOX traffic, full and back-pressure
        ib_q.delete(); update_cpu_inputs(); tx_log.delete();
        n0 = n_wr; rx_done = 1'b0; ob_done = 1'b0; sent_q.delete();
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [7:0] d;
                    repeat ($urandom_range(0, 3)) tick();
                    d = 8'($urandom);
                    sent_q.push_back(d);
                    send_rx(d);
                end
                rx_done = 1'b1;
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    repeat ($urandom_range(0, 5)) tick();
                    ob_q.push_back(8'($urandom));
                    update_cpu_inputs();
                end
                ob_done = 1'b1;
            end
            begin
                while (!rx_done || !ob_done) begin
                    force_full = ($urandom_range(0, 3) == 0);
                    tx_ready   = 1'($urandom_range(0, 1));
                    update_cpu_inputs();
                    tick();
                end
                force_full = 1'b0; tx_ready = 1'b1; update_cpu_inputs();
            end
        join
        wait_idle("random_timeout");
        repeat (4) tick();
        check("rand_wr_count", n_wr - n0, 24);
        check("rand_tx_count", tx_log.size(), 16);
        for (int i = 0; i < 24; i++) check("rand_inbox_data", ib_q[i], sent_q[i]);
        check("rand_wr_pending", wr_cyc_q.size(), 0);

        // reset in the middle of a dump, then a clean restart
        ib_q.delete();
        for (int i = 0; i < DEPTH; i++) ib_q.push_back(8'($urandom));
        update_cpu_inputs(); tx_log.delete(); tx_ready = 1'b1;
        start_dump(1'b0);
        for (k = 0; k < 400; k++) begin
            if (tx_log.size() >= 3) break;
            tick();
        end
        check("rst_dump_progress", tx_log.size() >= 3, 1);
        i_rst = 1'b0;
        tick();
        check_reset_outputs("midrst");
        exp_q.delete(); in_exp_q.delete(); wr_cyc_q.delete();
        tick();
        i_rst = 1'b1;
        ib_q.delete(); ib_q.push_back(8'h07); ib_q.push_back(8'h08); ib_q.push_back(8'h09);
        update_cpu_inputs(); tx_log.delete();
        tick();
        start_dump(1'b0);
        wait_idle("restart_timeout");
        check("restart_len", tx_log.size(), 4);
        check("restart_b0", tx_log[0], 8'h03);
        check("restart_b1", tx_log[1], 8'h07);
        check("restart_b3", tx_log[3], 8'h09);
        check("restart_pos", cpu_fifo_dmp_pos, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
